jpeg_mcu_scheduler: RTL and testbench
=====================================

Name: jpeg_mcu_scheduler

Overview:
- Sequences the JPEG entropy decoder block by block through each MCU, following the chroma subsampling mode.
- Selects the Huffman table for each block and tracks one DC predictor per component.
- Converts the decoder's DC differences into absolute DC values; AC coefficients pass through unchanged.
- Handles restart intervals: a marker handshake, then a predictor clear.
- Sits between the entropy decoder and the dequantiser/IDCT path.

Parameters:
- COEFF_W, 12, coefficient width in and out.
- CNT_W, 16, width of the MCU counter and the restart-interval counter.

Ports:
- clk  input  1  system clock.
- rst  input  1  synchronous, active-high reset.
- cfg_mode  input  2  0 = 4:4:4 (Y,Cb,Cr); 1 = 4:2:2 (Y,Y,Cb,Cr); 2 = 4:2:0 (Y,Y,Y,Y,Cb,Cr); 3 = gray (Y).
- cfg_mcu_count  input  CNT_W  MCUs in the scan.
- cfg_restart_interval  input  CNT_W  MCUs per restart interval; 0 = restarts disabled.
- start  input  1  begin a scan; cfg_* latched on this cycle.
- busy  output  1  high from the cycle after start until done.
- done  output  1  one-cycle pulse at scan end.
- dec_block_start  output  1  one-cycle pulse telling the decoder to decode one block.
- dec_comp  output  2  component of the current block: 0 = Y, 1 = Cb, 2 = Cr.
- huff_tbl_sel  output  1  0 for Y, 1 for Cb/Cr.
- dec_block_done  input  1  decoder finished the current block.
- coeff_valid  input  1  decoder coefficient strobe.
- coeff_index  input  6  zigzag index.
- coeff_value  input  COEFF_W  signed; a difference at index 0, absolute at AC.
- out_valid  output  1  registered coefficient strobe.
- out_index  output  6  zigzag index.
- out_value  output  COEFF_W  signed; absolute DC at index 0, AC passed through.
- out_comp  output  2  component of out_value.
- rst_marker_req  output  1  request to consume an RSTn marker.
- rst_marker_ack  input  1  marker consumed.
- err  output  1  sticky error flag; present only with the optional feature.

Behaviour:
- Reset: state IDLE. All outputs 0. Predictors, block counter, MCU counter and restart counter all 0.
- States:
  - IDLE, start=1: latch cfg; go to DONE if cfg_mcu_count==0, otherwise go to ISSUE. Clear all predictors.
  - ISSUE: pulse dec_block_start for exactly one cycle. dec_comp and huff_tbl_sel hold stable from ISSUE through the end of WAIT_BLK. Go to WAIT_BLK.
  - WAIT_BLK: coefficients are forwarded. On dec_block_done, go to NEXT.
  - NEXT (one cycle):
    - More blocks in this MCU: increment the block counter, go to ISSUE.
    - MCU complete: clear the block counter, increment the MCU counter.
      - MCU counter now equals cfg_mcu_count: go to DONE.
      - Otherwise, cfg_restart_interval != 0 and the restart counter reaches it: clear the restart counter, go to RST_WAIT.
      - Otherwise: go to ISSUE.
  - RST_WAIT: hold rst_marker_req=1. On rst_marker_ack, clear all three predictors, drop the request, go to ISSUE.
  - DONE: pulse done=1 with busy=0 in the same cycle, return to IDLE.
- No restart after the final MCU.
- Blocks per MCU: 3, 4, 6, 1 for modes 0–3. Components are ordered as listed under cfg_mode.
- Coefficient path:
  - A coeff_valid in WAIT_BLK produces out_* one cycle later.
  - coeff_valid in any other state is ignored.
  - At index 0: compute a COEFF_W+1-bit sum pred[comp]+coeff_value, saturate it to signed COEFF_W, output it and write it back to pred[comp].
  - AC values pass through unmodified.
- Timing constraint: the earliest dec_block_start is 1 cycle after start. From dec_block_done to the next dec_block_start is 2 cycles (NEXT, ISSUE).
- A dec_block_done coincident with coeff_valid: the coefficient is still forwarded.
- start while busy is ignored.
- rst asserted in any state returns to IDLE next cycle with all reset values; a pending request is dropped.
- rst_marker_ack outside RST_WAIT is ignored.

Optional Feature:
- Macro: MCU_COEFF_CHECK_EN.
- When defined:
  - A 7-bit counter counts coeff_valid in WAIT_BLK.
  - At dec_block_done (including any coincident coeff), a count != 64 sets err.
  - A coeff_index not equal to the expected sequential index also sets err.
  - err is sticky until rst or the next start.
- When undefined: no counter; err is tied to 0.

Test Plan:
- Mode 3, mcu_count=2, no restart. Block 1 DC diff +5, block 2 DC diff -3 -> out DC 5 then 2; exactly 2 dec_block_start pulses; done pulse after the second block_done.
- Mode 2, mcu_count=1 -> dec_comp sequence 0,0,0,0,1,2 and huff_tbl_sel 0,0,0,0,1,1. Y DC diffs 1,1,1,1 -> outputs 1,2,3,4. Cb diff 7 -> 7.
- Mode 0, mcu_count=3, restart_interval=1:
  - rst_marker_req after MCUs 1 and 2 only.
  - Delay ack by 5 cycles -> no dec_block_start while req is high.
  - Y DC diff 10 in each MCU -> 10 each time, because predictors are cleared.
- Saturation: pred=2040 plus diff +20 -> out 2047. AC value -37 at index 9 -> passes through as -37.
- rst mid-WAIT_BLK, then new start -> outputs are 0 after reset; a first DC diff of 4 -> out 4.
- MCU_COEFF_CHECK_EN: feed 63 coeffs then dec_block_done -> err=1 and it stays set. With exactly 64 coeffs -> err stays 0.

Source files
------------

// File: rtl/jpeg_mcu_scheduler.sv
// Block sequencer between the JPEG entropy decoder and the dequantiser/IDCT path:
// per-MCU block issue, Huffman table select, DC prediction and restart handling.
// Optional coefficient count/index check enabled by defining MCU_COEFF_CHECK_EN.
module jpeg_mcu_scheduler #(
  parameter int COEFF_W = 12,
  parameter int CNT_W   = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [1:0]                cfg_mode,
  input  logic [CNT_W-1:0]          cfg_mcu_count,
  input  logic [CNT_W-1:0]          cfg_restart_interval,
  input  logic                      start,
  output logic                      busy,
  output logic                      done,
  output logic                      dec_block_start,
  output logic [1:0]                dec_comp,
  output logic                      huff_tbl_sel,
  input  logic                      dec_block_done,
  input  logic                      coeff_valid,
  input  logic [5:0]                coeff_index,
  input  logic signed [COEFF_W-1:0] coeff_value,
  output logic                      out_valid,
  output logic [5:0]                out_index,
  output logic signed [COEFF_W-1:0] out_value,
  output logic [1:0]                out_comp,
  output logic                      rst_marker_req,
  input  logic                      rst_marker_ack,
  output logic                      err
);

  typedef enum logic [2:0] {IDLE, ISSUE, WAIT_BLK, NEXT, RST_WAIT, DONE} state_t;

  state_t                    state;
  logic [1:0]                mode_q;
  logic [CNT_W-1:0]          mcu_total, rst_ival, mcu_cnt, rst_cnt, mcu_nxt, rst_nxt;
  logic [2:0]                blk_cnt, blk_nxt, last_blk;
  logic [1:0]                nxt_comp;
  logic signed [COEFF_W-1:0] pred [3];
  logic signed [COEFF_W-1:0] pred_sel, dc_abs;
  logic signed [COEFF_W:0]   dc_sum;

  function automatic logic [2:0] blocks_per_mcu(input logic [1:0] m);
    case (m)
      2'd0:    return 3'd3;
      2'd1:    return 3'd4;
      2'd2:    return 3'd6;
      default: return 3'd1;
    endcase
  endfunction

  // Component order inside an MCU: luma blocks first, then Cb, then Cr.
  function automatic logic [1:0] comp_of(input logic [1:0] m, input logic [2:0] b);
    case (m)
      2'd0:    return b[1:0];
      2'd1:    return (b < 3'd2) ? 2'd0 : (b[1:0] - 2'd1);
      2'd2:    return (b < 3'd4) ? 2'd0 : ((b == 3'd4) ? 2'd1 : 2'd2);
      default: return 2'd0;
    endcase
  endfunction

  function automatic logic signed [COEFF_W-1:0] sat(input logic signed [COEFF_W:0] s);
    if (s > $signed({2'b00, {(COEFF_W-1){1'b1}}}))
      return {1'b0, {(COEFF_W-1){1'b1}}};
    else if (s < $signed({2'b11, {(COEFF_W-1){1'b0}}}))
      return {1'b1, {(COEFF_W-1){1'b0}}};
    else
      return s[COEFF_W-1:0];
  endfunction

  always_comb begin
    case (dec_comp)
      2'd1:    pred_sel = pred[1];
      2'd2:    pred_sel = pred[2];
      default: pred_sel = pred[0];
    endcase
    dc_sum   = $signed({pred_sel[COEFF_W-1], pred_sel}) +
               $signed({coeff_value[COEFF_W-1], coeff_value});
    dc_abs   = sat(dc_sum);
    mcu_nxt  = mcu_cnt + 1'b1;
    rst_nxt  = rst_cnt + 1'b1;
    blk_nxt  = blk_cnt + 3'd1;
    last_blk = blocks_per_mcu(mode_q) - 3'd1;
    nxt_comp = comp_of(mode_q, blk_nxt);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state           <= IDLE;
      mode_q          <= '0;
      mcu_total       <= '0;
      rst_ival        <= '0;
      mcu_cnt         <= '0;
      rst_cnt         <= '0;
      blk_cnt         <= '0;
      pred[0]         <= '0;
      pred[1]         <= '0;
      pred[2]         <= '0;
      busy            <= 1'b0;
      done            <= 1'b0;
      dec_block_start <= 1'b0;
      dec_comp        <= '0;
      huff_tbl_sel    <= 1'b0;
      out_valid       <= 1'b0;
      out_index       <= '0;
      out_value       <= '0;
      out_comp        <= '0;
      rst_marker_req  <= 1'b0;
    end else begin
      dec_block_start <= 1'b0;
      done            <= 1'b0;
      out_valid       <= 1'b0;
      // Coefficient stage: DC reconstructed against the component predictor.
      if (state == WAIT_BLK && coeff_valid) begin
        out_valid <= 1'b1;
        out_index <= coeff_index;
        out_comp  <= dec_comp;
        if (coeff_index == 6'd0) begin
          out_value <= dc_abs;
          case (dec_comp)
            2'd1:    pred[1] <= dc_abs;
            2'd2:    pred[2] <= dc_abs;
            default: pred[0] <= dc_abs;
          endcase
        end else begin
          out_value <= coeff_value;
        end
      end
      case (state)
        IDLE: if (start) begin
          mode_q       <= cfg_mode;
          mcu_total    <= cfg_mcu_count;
          rst_ival     <= cfg_restart_interval;
          mcu_cnt      <= '0;
          rst_cnt      <= '0;
          blk_cnt      <= '0;
          pred[0]      <= '0;
          pred[1]      <= '0;
          pred[2]      <= '0;
          dec_comp     <= 2'd0;
          huff_tbl_sel <= 1'b0;
          if (cfg_mcu_count == '0) begin
            state <= DONE;
            done  <= 1'b1;
          end else begin
            state           <= ISSUE;
            busy            <= 1'b1;
            dec_block_start <= 1'b1;
          end
        end
        ISSUE:    state <= WAIT_BLK;
        WAIT_BLK: if (dec_block_done) state <= NEXT;
        NEXT: begin
          if (blk_cnt != last_blk) begin
            blk_cnt         <= blk_nxt;
            dec_comp        <= nxt_comp;
            huff_tbl_sel    <= (nxt_comp != 2'd0);
            state           <= ISSUE;
            dec_block_start <= 1'b1;
          end else begin
            blk_cnt      <= '0;
            mcu_cnt      <= mcu_nxt;
            dec_comp     <= 2'd0;
            huff_tbl_sel <= 1'b0;
            if (mcu_nxt == mcu_total) begin
              state <= DONE;
              busy  <= 1'b0;
              done  <= 1'b1;
            end else if (rst_ival != '0 && rst_nxt == rst_ival) begin
              rst_cnt        <= '0;
              state          <= RST_WAIT;
              rst_marker_req <= 1'b1;
            end else begin
              rst_cnt         <= rst_nxt;
              state           <= ISSUE;
              dec_block_start <= 1'b1;
            end
          end
        end
        RST_WAIT: if (rst_marker_ack) begin
          pred[0]         <= '0;
          pred[1]         <= '0;
          pred[2]         <= '0;
          rst_marker_req  <= 1'b0;
          state           <= ISSUE;
          dec_block_start <= 1'b1;
        end
        DONE:     state <= IDLE;
        default:  state <= IDLE;
      endcase
    end
  end

`ifdef MCU_COEFF_CHECK_EN
  logic [6:0] coef_cnt, coef_total;

  assign coef_total = coef_cnt + {6'd0, coeff_valid};

  // Block must deliver indices 0..63 in order, closing exactly at 64.
  always_ff @(posedge clk) begin
    if (rst) begin
      coef_cnt <= '0;
      err      <= 1'b0;
    end else if (state == IDLE && start) begin
      coef_cnt <= '0;
      err      <= 1'b0;
    end else if (state == WAIT_BLK) begin
      if (coeff_valid && (coef_cnt[6] || coeff_index != coef_cnt[5:0]))
        err <= 1'b1;
      if (dec_block_done) begin
        coef_cnt <= '0;
        if (coef_total != 7'd64) err <= 1'b1;
      end else begin
        coef_cnt <= coef_total;
      end
    end
  end
`else
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_jpeg_mcu_scheduler.sv
// Directed bench for jpeg_mcu_scheduler: a decoder model drives blocks, a scoreboard
// queue holds expected coefficients, and a negedge monitor pops and compares them.
module tb_jpeg_mcu_scheduler;
  localparam int COEFF_W = 12;
  localparam int CNT_W   = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                      rst, start, busy, done, dec_block_start, huff_tbl_sel;
  logic [1:0]                cfg_mode, dec_comp, out_comp;
  logic [CNT_W-1:0]          cfg_mcu_count, cfg_restart_interval;
  logic                      dec_block_done, coeff_valid, out_valid;
  logic [5:0]                coeff_index, out_index;
  logic signed [COEFF_W-1:0] coeff_value, out_value;
  logic                      rst_marker_req, rst_marker_ack, err;

  jpeg_mcu_scheduler #(.COEFF_W(COEFF_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .cfg_mode(cfg_mode), .cfg_mcu_count(cfg_mcu_count),
    .cfg_restart_interval(cfg_restart_interval), .start(start), .busy(busy),
    .done(done), .dec_block_start(dec_block_start), .dec_comp(dec_comp),
    .huff_tbl_sel(huff_tbl_sel), .dec_block_done(dec_block_done),
    .coeff_valid(coeff_valid), .coeff_index(coeff_index), .coeff_value(coeff_value),
    .out_valid(out_valid), .out_index(out_index), .out_value(out_value),
    .out_comp(out_comp), .rst_marker_req(rst_marker_req),
    .rst_marker_ack(rst_marker_ack), .err(err)
  );

  typedef struct {int idx; int val; int comp;} exp_t;
  exp_t q[$];

  int pass_cnt  = 0;
  int total_cnt = 0;
  int nstart    = 0;
  int nreq      = 0;
  int bad_start = 0;
  logic req_q   = 1'b0;

  int t2_comp [6] = '{0, 0, 0, 0, 1, 2};
  int t2_diff [6] = '{1, 1, 1, 1, 7, -2};
  int t2_exp  [6] = '{1, 2, 3, 4, 7, -2};
  int t3_diff [3] = '{10, 3, -4};
  int t5_comp [8] = '{0, 0, 1, 2, 0, 0, 1, 2};
  int t5_diff [8] = '{3, 3, 2, 5, 1, 1, 2, -1};
  int t5_exp  [8] = '{3, 6, 2, 5, 7, 8, 4, 4};

  task automatic chk(input string tag, input int obs, input int exp);
    total_cnt = total_cnt + 1;
    assert (obs === exp) pass_cnt = pass_cnt + 1;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  always @(negedge clk) begin : monitor
    exp_t e;
    int   v;
    if (out_valid) begin
      if (q.size() == 0) begin
        chk("unexpected_out", int'(out_index), -1);
      end else begin
        e = q.pop_front();
        v = $signed(out_value);
        chk("out_index", int'(out_index), e.idx);
        chk("out_value", v, e.val);
        chk("out_comp", int'(out_comp), e.comp);
      end
    end
    if (dec_block_start) nstart <= nstart + 1;
    if (rst_marker_req && !req_q) nreq <= nreq + 1;
    if (rst_marker_req && dec_block_start) bad_start <= bad_start + 1;
    req_q <= rst_marker_req;
  end

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected finish");
    $fatal(1, "timeout");
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic start_scan(input int mode, input int mcu, input int ri);
    cfg_mode             = 2'(mode);
    cfg_mcu_count        = CNT_W'(mcu);
    cfg_restart_interval = CNT_W'(ri);
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_bs(output int waited);
    waited = 0;
    while (!dec_block_start && waited < 40) begin
      tick();
      waited++;
    end
    chk("block_start_seen", int'(dec_block_start), 1);
  endtask

  task automatic do_block(input string tag, input int comp, input int diff,
                          input int dc_exp, input int n, output int waited);
    exp_t e;
    wait_bs(waited);
    chk({tag, "_comp"}, int'(dec_comp), comp);
    chk({tag, "_huff"}, int'(huff_tbl_sel), int'(comp != 0));
    // Stray strobe while the block is only being issued must be dropped.
    coeff_valid = 1'b1;
    coeff_index = 6'd0;
    coeff_value = 12'sd99;
    tick();
    for (int i = 0; i < n; i++) begin
      coeff_valid    = 1'b1;
      coeff_index    = 6'(i);
      coeff_value    = (i == 0) ? COEFF_W'(diff) : COEFF_W'(8 - 5 * i);
      dec_block_done = (i == n - 1);
      e.idx  = i;
      e.val  = (i == 0) ? dc_exp : 8 - 5 * i;
      e.comp = comp;
      q.push_back(e);
      if (i == n - 1) chk({tag, "_comp_hold"}, int'(dec_comp), comp);
      tick();
    end
    coeff_valid    = 1'b0;
    dec_block_done = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    int w;
    w = 0;
    while (!done && w < 40) begin
      tick();
      w++;
    end
    chk({tag, "_done"}, int'(done), 1);
    chk({tag, "_busy_at_done"}, int'(busy), 0);
    tick();
    chk({tag, "_done_pulse"}, int'(done), 0);
  endtask

  task automatic chk_idle_outputs(input string tag);
    chk({tag, "_busy"}, int'(busy), 0);
    chk({tag, "_done"}, int'(done), 0);
    chk({tag, "_dbs"}, int'(dec_block_start), 0);
    chk({tag, "_dec_comp"}, int'(dec_comp), 0);
    chk({tag, "_huff"}, int'(huff_tbl_sel), 0);
    chk({tag, "_out_valid"}, int'(out_valid), 0);
    chk({tag, "_out_index"}, int'(out_index), 0);
    chk({tag, "_out_value"}, int'(out_value), 0);
    chk({tag, "_out_comp"}, int'(out_comp), 0);
    chk({tag, "_req"}, int'(rst_marker_req), 0);
    chk({tag, "_err"}, int'(err), 0);
  endtask

  initial begin : stimulus
    int w, s0, r0;
    exp_t e;
    rst = 1'b1; start = 1'b0; cfg_mode = '0; cfg_mcu_count = '0;
    cfg_restart_interval = '0; dec_block_done = 1'b0; coeff_valid = 1'b0;
    coeff_index = '0; coeff_value = '0; rst_marker_ack = 1'b0;
    repeat (3) tick();
    chk_idle_outputs("reset");
    rst = 1'b0;
    tick();

    // Gray, two MCUs; a start while busy with different cfg must not disturb the scan.
    s0 = nstart;
    start_scan(3, 2, 0);
    chk("t1_busy", int'(busy), 1);
    do_block("t1b1", 0, 5, 5, 4, w);
    chk("t1_first_latency", w, 0);
    cfg_mode = 2'd2; cfg_mcu_count = 16'd5; start = 1'b1;
    tick();
    start = 1'b0;
    do_block("t1b2", 0, -3, 2, 4, w);
    wait_done("t1");
    chk("t1_starts", nstart - s0, 2);

    // 4:2:0 single MCU: component order, table select, luma DC accumulation.
    s0 = nstart;
    start_scan(2, 1, 0);
    for (int b = 0; b < 6; b++) begin
      do_block("t2", t2_comp[b], t2_diff[b], t2_exp[b], 3, w);
      chk("t2_latency", w, (b == 0) ? 0 : 1);
    end
    wait_done("t2");
    chk("t2_starts", nstart - s0, 6);

    // 4:4:4 with a restart after every MCU; ack delayed by 5 cycles.
    r0 = nreq;
    start_scan(0, 3, 1);
    for (int m = 0; m < 3; m++) begin
      for (int b = 0; b < 3; b++) do_block("t3", b, t3_diff[b], t3_diff[b], 2, w);
      if (m < 2) begin
        w = 0;
        while (!rst_marker_req && w < 20) begin
          tick();
          w++;
        end
        chk("t3_req", int'(rst_marker_req), 1);
        rst_marker_ack = 1'b0;
        for (int k = 0; k < 5; k++) begin
          tick();
          chk("t3_no_start_while_req", int'(dec_block_start), 0);
          chk("t3_req_held", int'(rst_marker_req), 1);
        end
        rst_marker_ack = 1'b1;
        tick();
        rst_marker_ack = 1'b0;
        chk("t3_req_dropped", int'(rst_marker_req), 0);
      end
    end
    wait_done("t3");
    chk("t3_req_count", nreq - r0, 2);
    chk("t3_start_during_req", bad_start, 0);

    // Positive and negative DC saturation; AC -37 at index 9 passes through.
    start_scan(3, 2, 0);
    do_block("t4p1", 0, 2040, 2040, 4, w);
    do_block("t4p2", 0, 20, 2047, 10, w);
    wait_done("t4p");
    start_scan(3, 2, 0);
    do_block("t4n1", 0, -2048, -2048, 4, w);
    do_block("t4n2", 0, -5, -2048, 4, w);
    wait_done("t4n");

    // 4:2:2 two MCUs, predictors carry over; interval 2 hits only at the final MCU.
    r0 = nreq;
    start_scan(1, 2, 2);
    for (int b = 0; b < 8; b++) do_block("t5", t5_comp[b], t5_diff[b], t5_exp[b], 2, w);
    wait_done("t5");
    chk("t5_no_restart_at_end", nreq - r0, 0);

    // Zero-length scan.
    s0 = nstart;
    start_scan(3, 0, 0);
    wait_done("t6");
    chk("t6_no_blocks", nstart - s0, 0);

    // Reset in the middle of a block, then a fresh scan.
    start_scan(3, 2, 0);
    wait_bs(w);
    tick();
    coeff_valid = 1'b1; coeff_index = 6'd0; coeff_value = 12'sd100;
    e.idx = 0; e.val = 100; e.comp = 0;
    q.push_back(e);
    tick();
    coeff_valid = 1'b0;
    rst = 1'b1;
    tick();
    chk_idle_outputs("t7_after_rst");
    rst = 1'b0;
    tick();
    start_scan(3, 1, 0);
    do_block("t7", 0, 4, 4, 4, w);
    wait_done("t7");

`ifdef MCU_COEFF_CHECK_EN
    start_scan(3, 1, 0);
    chk("t8_err_cleared", int'(err), 0);
    do_block("t8short", 0, 1, 1, 63, w);
    chk("t8_err_set", int'(err), 1);
    repeat (3) tick();
    chk("t8_err_sticky", int'(err), 1);
    start_scan(3, 1, 0);
    chk("t8_err_cleared2", int'(err), 0);
    do_block("t8full", 0, 1, 1, 64, w);
    chk("t8_err_full_ok", int'(err), 0);
    wait_done("t8");
    chk("t8_err_after", int'(err), 0);
`else
    chk("err_tied_low", int'(err), 0);
`endif

    repeat (3) tick();
    chk("queue_empty", q.size(), 0);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
